step_sequencer: RTL and testbench
=================================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have parameter STEPS, default 8, meaning pattern length in steps (power of two).
REQ-002 SHALL have parameter TEMPO_W, default 24, meaning tempo/gate counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse; begin playback at step 0.
REQ-006 SHALL have port stop  input  1  single-cycle pulse; halt playback.
REQ-007 SHALL have port tempo_period  input  TEMPO_W  clocks per step minus 1.
REQ-008 SHALL have port gate_len  input  TEMPO_W  clocks per step that gate is high.
REQ-009 SHALL have port wr_en  input  1  pattern write strobe.
REQ-010 SHALL have port wr_addr  input  log2(STEPS)  pattern step to write.
REQ-011 SHALL have port wr_data  input  19  bit 18 = rest flag, bits 17:0 = tuning increment.
REQ-012 SHALL have port tuning_increment  output  18  increment for the oscillator; registered.
REQ-013 SHALL have port gate  output  1  note-on; registered.
REQ-014 SHALL have port step_idx  output  log2(STEPS)  current step; registered.
REQ-015 SHALL have port running  output  1  high in RUN state.
REQ-016 SHALL have port step_tick  output  1  one-cycle pulse on each step advance.

Function
REQ-017 SHALL implement two states, IDLE and RUN.
REQ-018 In IDLE, start SHALL, on the next edge, enter RUN with step_idx=0, tempo counter=0, tuning_increment=pattern[0][17:0] and running=1.
REQ-019 In RUN, the tempo counter SHALL increment each cycle while counter < tempo_period; when counter >= tempo_period it SHALL clear to 0, and step_idx SHALL advance by 1, wrapping from STEPS-1 to 0.
REQ-020 On that same edge, tuning_increment SHALL load pattern[new step_idx][17:0], and step_tick SHALL be 1 for exactly that cycle.
REQ-021 In RUN, gate SHALL be 1 iff counter < gate_len and the current step's rest flag is 0. Consequences: gate_len=0 gives no gate; gate_len > tempo_period gives a continuous gate across non-rest steps.
REQ-022 tempo_period=0 SHALL advance one step every cycle.
REQ-023 tempo_period or gate_len changes SHALL take effect on the next cycle. A counter above a newly lowered tempo_period SHALL wrap on the next cycle (>= compare).
REQ-024 stop in RUN SHALL, on the next edge, enter IDLE with gate=0, running=0 and step_tick=0. tuning_increment and step_idx SHALL hold.
REQ-025 start asserted in RUN SHALL restart from step 0, as in REQ-018.
REQ-026 If start and stop are asserted together, stop SHALL win.
REQ-027 wr_en SHALL write pattern[wr_addr] on the edge in any state.
REQ-028 A write to the currently playing step SHALL NOT change tuning_increment or the rest flag until that step is next loaded.
REQ-029 If a write coincides with a load of the same step, the load SHALL see the new data (write-first).
REQ-030 In IDLE, gate and step_tick SHALL be 0.

Reset
REQ-031 rst SHALL force: state=IDLE, counter=0, step_idx=0, tuning_increment=0, gate=0, running=0, step_tick=0, and all pattern entries=0.
REQ-032 rst SHALL have priority over start, stop and wr_en, including mid-step in RUN.

Structure
REQ-033 Step width, rest-bit position (18) and increment width (18) SHALL live in a shared package, seq_pkg, along with the state encoding.
REQ-034 The tempo counter and its wrap compare SHALL be one sub-module, tempo_divider, with ports clk, rst, enable, clear, period and outputs count and tick.
REQ-035 Pattern storage SHALL be flip-flops, not inferred RAM.

Verification
REQ-036 Write steps 0..7 with increments 100..107 (no rest), tempo_period=3, gate_len=2, pulse start. Required: step_idx advances every 4 cycles; tuning_increment follows 100..107,100; gate is high 2 of every 4 cycles; step_tick is high once per step.
REQ-037 Set the rest flag on step 2 and gate_len=10 with tempo_period=3. Required: gate is continuous on steps 0-1, low for all of step 2, then high again on step 3.
REQ-038 Assert start and stop in the same cycle during RUN. Required: IDLE next cycle, gate=0, running=0, step_idx held.
REQ-039 During step 1, write step 1 with 500. Required: tuning_increment is unchanged for the current step and shows 500 on the next visit to step 1.
REQ-040 Run with tempo_period=9, lower it to 2 when the counter reads 7. Required: wrap on the next cycle, followed by 3-cycle steps.
REQ-041 Assert rst mid-RUN. Required: all outputs 0 on the next cycle, and after a subsequent start tuning_increment=0 (pattern cleared).

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the step sequencer: pattern entry layout
// (rest flag above the oscillator tuning increment) and FSM state encoding.
package seq_pkg;

  localparam int STEP_W   = 19;  // one pattern entry
  localparam int REST_BIT = 18;  // rest flag position within an entry
  localparam int INC_W    = 18;  // tuning increment width

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Field order matches wr_data: bit 18 rest, bits 17:0 increment.
  typedef struct packed {
    logic             rest;
    logic [INC_W-1:0] inc;
  } step_t;

endpackage

// File: rtl/step_sequencer_tempo_divider.sv
// tempo_divider: per-step clock counter with a wrap compare.
//   clk, rst    : clock, synchronous active-high reset
//   enable      : count this cycle
//   clear       : force the count to 0 (wins over enable)
//   period      : clocks per step minus 1
//   count       : current count within the step
//   tick        : combinational, high when an enabled count wraps this edge
module tempo_divider #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         clear,
  input  logic [W-1:0] period,
  output logic [W-1:0] count,
  output logic         tick
);

  // >= rather than == so a period lowered below the current count still
  // wraps on the very next edge instead of running all the way around.
  assign tick = enable && (count >= period);

  always_ff @(posedge clk) begin
    if (rst)         count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= tick ? '0 : count + W'(1);
  end

endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: STEPS-entry note pattern player. Each step lasts
// tempo_period+1 clocks; gate is high for the first gate_len clocks of
// non-rest steps. Pattern entries are flip-flops writable at any time.
//   clk, rst          : clock, synchronous active-high reset
//   start, stop       : playback control pulses (stop wins)
//   tempo_period      : clocks per step minus 1
//   gate_len          : clocks per step with gate high
//   wr_en/addr/data   : pattern write port, data = {rest, increment}
//   tuning_increment  : increment for the current step (registered)
//   gate, step_idx    : note-on and current step (registered)
//   running           : high while playing
//   step_tick         : one-cycle pulse on every step advance
module step_sequencer
  import seq_pkg::*;
#(
  parameter int STEPS   = 8,
  parameter int TEMPO_W = 24,
  localparam int AW     = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [TEMPO_W-1:0] tempo_period,
  input  logic [TEMPO_W-1:0] gate_len,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [STEP_W-1:0]  wr_data,
  output logic [INC_W-1:0]   tuning_increment,
  output logic               gate,
  output logic [AW-1:0]      step_idx,
  output logic               running,
  output logic               step_tick
);

  state_t                    state;
  step_t [STEPS-1:0]         pattern;
  logic                      cur_rest;
  logic [TEMPO_W-1:0]        count;
  logic                      adv;
  logic                      run_go;
  logic [AW-1:0]             next_step;
  logic [AW-1:0]             load_addr;
  step_t                     load_val;

  assign run_go    = (state == S_RUN) && !start && !stop;
  assign next_step = step_idx + AW'(1);  // STEPS is a power of two: wraps
  assign load_addr = start ? '0 : next_step;

  // Write-first: a write landing on the entry being loaded is seen by the load.
  always_comb begin
    load_val = pattern[load_addr];
    if (wr_en && (wr_addr == load_addr)) load_val = step_t'(wr_data);
  end

  tempo_divider #(.W(TEMPO_W)) u_div (
    .clk    (clk),
    .rst    (rst),
    .enable (run_go),
    .clear  (start || stop),
    .period (tempo_period),
    .count  (count),
    .tick   (adv)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      pattern          <= '0;
      cur_rest         <= 1'b0;
      step_idx         <= '0;
      tuning_increment <= '0;
      gate             <= 1'b0;
      running          <= 1'b0;
      step_tick        <= 1'b0;
    end else begin
      if (wr_en) pattern[wr_addr] <= step_t'(wr_data);
      step_tick <= 1'b0;
      if (stop) begin
        state   <= S_IDLE;
        gate    <= 1'b0;
        running <= 1'b0;
      end else if (start) begin
        state            <= S_RUN;
        running          <= 1'b1;
        step_idx         <= '0;
        tuning_increment <= load_val.inc;
        cur_rest         <= load_val.rest;
        gate             <= (gate_len != '0) && !load_val.rest;
      end else if (state == S_RUN) begin
        if (adv) begin
          step_idx         <= next_step;
          tuning_increment <= load_val.inc;
          cur_rest         <= load_val.rest;
          step_tick        <= 1'b1;
          gate             <= (gate_len != '0) && !load_val.rest;
        end else begin
          // Gate follows the count the divider will hold after this edge.
          gate <= ((count + TEMPO_W'(1)) < gate_len) && !cur_rest;
        end
      end else begin
        gate <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: directed scenarios with
// closed-form expectations plus a randomized run against a step-level model.
module tb_step_sequencer;
  localparam int STEPS = 8;
  localparam int TW    = 24;

  logic          clk = 1'b0;
  logic          rst, start, stop, wr_en;
  logic [TW-1:0] tempo_period, gate_len;
  logic [2:0]    wr_addr;
  logic [18:0]   wr_data;
  logic [17:0]   tuning_increment;
  logic          gate, running, step_tick;
  logic [2:0]    step_idx;

  int n_chk = 0;
  int n_pass = 0;

  // Model: pattern plus a playhead described as (step, position in step).
  logic [18:0] m_pat [STEPS];
  bit          m_run, m_rest, m_gate, m_tick;
  int          m_pos, m_step;
  logic [17:0] m_inc;

  step_sequencer #(.STEPS(STEPS), .TEMPO_W(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .tempo_period(tempo_period), .gate_len(gate_len),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .tuning_increment(tuning_increment), .gate(gate), .step_idx(step_idx),
    .running(running), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < STEPS; i++) m_pat[i] = '0;
      m_run = 0; m_pos = 0; m_step = 0; m_inc = '0; m_rest = 0;
      m_gate = 0; m_tick = 0;
      return;
    end
    if (wr_en) m_pat[wr_addr] = wr_data;  // before any load: write-first
    m_tick = 0;
    if (stop) begin
      m_run = 0;
    end else if (start) begin
      m_run = 1; m_pos = 0; m_step = 0;
      m_inc = m_pat[0][17:0]; m_rest = m_pat[0][18];
    end else if (m_run) begin
      if (m_pos >= int'(tempo_period)) begin
        m_pos = 0; m_step = (m_step + 1) % STEPS; m_tick = 1;
        m_inc = m_pat[m_step][17:0]; m_rest = m_pat[m_step][18];
      end else m_pos = m_pos + 1;
    end
    m_gate = m_run && (m_pos < int'(gate_len)) && !m_rest;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic wr(input int a, input logic [18:0] d);
    wr_en = 1; wr_addr = 3'(a); wr_data = d;
    cyc();
    wr_en = 0;
  endtask

  task automatic test_reset();
    rst = 1; start = 1; wr_en = 1; wr_addr = 3'd0; wr_data = 19'd77;
    cyc();
    rst = 0; start = 0; wr_en = 0;
    n_chk++; if (tuning_increment !== 18'd0) $display("FAIL reset_inc got %0d exp 0", tuning_increment); else n_pass++;
    n_chk++; if (gate !== 1'b0) $display("FAIL reset_gate got %b exp 0", gate); else n_pass++;
    n_chk++; if (step_idx !== 3'd0) $display("FAIL reset_step got %0d exp 0", step_idx); else n_pass++;
    n_chk++; if (running !== 1'b0) $display("FAIL reset_running got %b exp 0", running); else n_pass++;
    n_chk++; if (step_tick !== 1'b0) $display("FAIL reset_tick got %b exp 0", step_tick); else n_pass++;
  endtask

  task automatic test_basic();
    logic [23:0] got, exp;
    int pos, st;
    for (int i = 0; i < STEPS; i++) wr(i, 19'(100 + i));
    tempo_period = 3; gate_len = 2;
    start = 1; cyc(); start = 0;
    for (int k = 0; k < 36; k++) begin
      if (k > 0) cyc();
      pos = k % 4; st = (k / 4) % STEPS;
      exp = {1'b1, (k > 0 && pos == 0), (pos < 2), 3'(st), 18'(100 + st)};
      got = {running, step_tick, gate, step_idx, tuning_increment};
      n_chk++; if (got !== exp) $display("FAIL basic k=%0d got %h exp %h", k, got, exp); else n_pass++;
    end
  endtask

  task automatic test_rest();
    logic [3:0] got, exp;
    wr(2, {1'b1, 18'd102});
    gate_len = 10; tempo_period = 3;
    start = 1; cyc(); start = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) cyc();
      exp = {((k / 4) != 2), 3'(k / 4)};
      got = {gate, step_idx};
      n_chk++; if (got !== exp) $display("FAIL rest k=%0d got %h exp %h", k, got, exp); else n_pass++;
    end
  endtask

  task automatic test_start_stop();
    logic [23:0] got, exp;
    // Playback sits on step 4 (increment 104) from the previous scenario.
    start = 1; stop = 1; cyc(); start = 0; stop = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      exp = {1'b0, 1'b0, 1'b0, 3'd4, 18'd104};
      got = {running, step_tick, gate, step_idx, tuning_increment};
      n_chk++; if (got !== exp) $display("FAIL start_stop k=%0d got %h exp %h", k, got, exp); else n_pass++;
    end
  endtask

  task automatic test_write_current();
    logic [20:0] got, exp;
    int st;
    gate_len = 2;
    start = 1; cyc(); start = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        if (k == 6) begin wr_en = 1; wr_addr = 3'd1; wr_data = 19'd500; end
        cyc();
        wr_en = 0;
      end
      st = (k / 4) % STEPS;
      exp = {3'(st), (st == 1 && k >= 32) ? 18'd500 : 18'(100 + st)};
      got = {step_idx, tuning_increment};
      n_chk++; if (got !== exp) $display("FAIL write_current k=%0d got %h exp %h", k, got, exp); else n_pass++;
    end
  endtask

  task automatic test_tempo_change();
    logic [3:0] got, exp;
    int j;
    tempo_period = 9;
    start = 1; cyc(); start = 0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 8) tempo_period = 2;  // count reads 7 during this cycle
      cyc();
      j = k - 8;
      exp = (k < 8) ? 4'b0000 : {(j % 3 == 0), 3'(1 + j / 3)};
      got = {step_tick, step_idx};
      n_chk++; if (got !== exp) $display("FAIL tempo_change k=%0d got %h exp %h", k, got, exp); else n_pass++;
    end
  endtask

  task automatic test_period_zero();
    logic [4:0] got, exp;
    tempo_period = 0; gate_len = 0;
    start = 1; cyc(); start = 0;
    for (int k = 0; k < 11; k++) begin
      if (k > 0) cyc();
      exp = {(k > 0), 1'b0, 3'(k % STEPS)};
      got = {step_tick, gate, step_idx};
      n_chk++; if (got !== exp) $display("FAIL period_zero k=%0d got %h exp %h", k, got, exp); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_run();
    logic [23:0] got;
    tempo_period = 3; gate_len = 2;
    start = 1; cyc(); start = 0;
    repeat (5) cyc();
    rst = 1; cyc(); rst = 0;
    got = {running, step_tick, gate, step_idx, tuning_increment};
    n_chk++; if (got !== 24'h0) $display("FAIL reset_mid_run got %h exp 000000", got); else n_pass++;
    start = 1; cyc(); start = 0;
    got = {running, step_tick, gate, step_idx, tuning_increment};
    n_chk++; if (got !== 24'h a00000) $display("FAIL reset_cleared_pattern got %h exp a00000", got); else n_pass++;
  endtask

  task automatic test_random();
    logic [23:0] got, exp;
    for (int k = 0; k < 600; k++) begin
      rst     = ($urandom % 250) == 0;
      start   = ($urandom % 23) == 0;
      stop    = ($urandom % 41) == 0;
      wr_en   = ($urandom % 5) == 0;
      wr_addr = 3'($urandom);
      wr_data = {($urandom % 4) == 0, 18'($urandom)};
      if ($urandom % 37 == 0) tempo_period = TW'($urandom_range(0, 5));
      if ($urandom % 29 == 0) gate_len = TW'($urandom_range(0, 7));
      cyc();
      rst = 0; start = 0; stop = 0; wr_en = 0;
      exp = {m_run, m_tick, m_gate, 3'(m_step), m_inc};
      got = {running, step_tick, gate, step_idx, tuning_increment};
      n_chk++; if (got !== exp) $display("FAIL random k=%0d got %h exp %h", k, got, exp); else n_pass++;
    end
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    tempo_period = 3; gate_len = 2;
    cyc(); cyc();
    rst = 0;
    test_reset();
    test_basic();
    test_rest();
    test_start_stop();
    test_write_current();
    test_tempo_change();
    test_period_zero();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
